// File: rtl/alsu_cmd_sequencer_pkg.sv
// Shared definitions for the ALSU command sequencer: FSM encoding, command field layout, defaults.
// The ALSU top-level wrapper decodes commands with the same field positions.
package alsu_cmd_sequencer_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_LAT   = 2;

  localparam int CMD_W = 16;
  localparam int RES_W = 6;

  // {opcode, A, B, cin, serial_in, direction, red_op_A, red_op_B, byPass_A, byPass_B}
  localparam int OPCODE_MSB    = 15;
  localparam int OPCODE_LSB    = 13;
  localparam int A_MSB         = 12;
  localparam int A_LSB         = 10;
  localparam int B_MSB         = 9;
  localparam int B_LSB         = 7;
  localparam int CIN_BIT       = 6;
  localparam int SERIAL_IN_BIT = 5;
  localparam int DIRECTION_BIT = 4;
  localparam int RED_OP_A_BIT  = 3;
  localparam int RED_OP_B_BIT  = 2;
  localparam int BYPASS_A_BIT  = 1;
  localparam int BYPASS_B_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } alsu_cmd_t;

  function automatic alsu_cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    alsu_cmd_t c;
    c.opcode    = raw[OPCODE_MSB:OPCODE_LSB];
    c.a         = raw[A_MSB:A_LSB];
    c.b         = raw[B_MSB:B_LSB];
    c.cin       = raw[CIN_BIT];
    c.serial_in = raw[SERIAL_IN_BIT];
    c.direction = raw[DIRECTION_BIT];
    c.red_op_a  = raw[RED_OP_A_BIT];
    c.red_op_b  = raw[RED_OP_B_BIT];
    c.bypass_a  = raw[BYPASS_A_BIT];
    c.bypass_b  = raw[BYPASS_B_BIT];
    return c;
  endfunction

endpackage

// File: rtl/alsu_cmd_sequencer_if.sv
// Command, ALSU-drive and result bundle of the sequencer.
// err_clr/err_cnt exist only when ALSU_SEQ_ERR_CNT_EN is defined.
interface alsu_cmd_sequencer_if
  import alsu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  logic                     cmd_valid;
  logic [CMD_W-1:0]         cmd_data;
  logic                     cmd_ready;

  logic [2:0]               alsu_A;
  logic [2:0]               alsu_B;
  logic [2:0]               alsu_opcode;
  logic                     alsu_cin;
  logic                     alsu_serial_in;
  logic                     alsu_direction;
  logic                     alsu_red_op_A;
  logic                     alsu_red_op_B;
  logic                     alsu_byPass_A;
  logic                     alsu_byPass_B;
  logic [RES_W-1:0]         alsu_out;
  logic                     alsu_valid;

  logic [RES_W-1:0]         res;
  logic                     res_err;
  logic                     res_valid;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;
`ifdef ALSU_SEQ_ERR_CNT_EN
  logic                     err_clr;
  logic [7:0]               err_cnt;
`endif

  // Environment side: command producer plus the ALSU datapath itself.
  modport master (
    output cmd_valid, cmd_data, alsu_out, alsu_valid,
`ifdef ALSU_SEQ_ERR_CNT_EN
    output err_clr, input err_cnt,
`endif
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_byPass_A,
           alsu_byPass_B, res, res_err, res_valid, busy, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_data, alsu_out, alsu_valid,
`ifdef ALSU_SEQ_ERR_CNT_EN
    input err_clr, output err_cnt,
`endif
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_byPass_A,
           alsu_byPass_B, res, res_err, res_valid, busy, fifo_count
  );

endinterface

// File: rtl/alsu_cmd_fifo.sv
// Synchronous DEPTH x WIDTH command FIFO with occupancy count; head word is visible
// combinationally so the sequencer can pop into its command register on one edge.
module alsu_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full/empty gate the requests so a push when full or a pop when empty is a no-op.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// Buffers ALSU commands, issues them one at a time, waits LAT cycles and captures the result.
// Optional invalid-result counter is built when ALSU_SEQ_ERR_CNT_EN is defined.
module alsu_cmd_sequencer
  import alsu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LAT   = DEFAULT_LAT
) (
  input logic                clk,
  input logic                rst,
  alsu_cmd_sequencer_if.slave bus
);

  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [3:0] LAT_LOAD = 4'(LAT);

  seq_state_e       state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             load_wait;
  logic             capture;
  alsu_cmd_t        cmd_f;

  alsu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.cmd_valid),
    .din_i   (bus.cmd_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (wait_q == 4'd1) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    load_wait = (state_q == ST_ISSUE);
    capture   = (state_q == ST_CAPTURE);
  end

  // The command register is the only source of the ALSU inputs, so they move only on a pop.
  always_comb begin
    wait_d      = wait_q;
    cmd_d       = cmd_q;
    res_d       = res_q;
    res_err_d   = res_err_q;
    res_valid_d = capture;
    if (fifo_pop)                       cmd_d  = fifo_dout;
    if (load_wait)                      wait_d = LAT_LOAD;
    else if (state_q == ST_WAIT)        wait_d = wait_q - 4'd1;
    if (capture) begin
      res_d     = bus.alsu_out;
      res_err_d = !bus.alsu_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q      <= '0;
      cmd_q       <= '0;
      res_q       <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      cmd_q       <= cmd_d;
      res_q       <= res_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_f = unpack_cmd(cmd_q);

  assign bus.alsu_opcode    = cmd_f.opcode;
  assign bus.alsu_A         = cmd_f.a;
  assign bus.alsu_B         = cmd_f.b;
  assign bus.alsu_cin       = cmd_f.cin;
  assign bus.alsu_serial_in = cmd_f.serial_in;
  assign bus.alsu_direction = cmd_f.direction;
  assign bus.alsu_red_op_A  = cmd_f.red_op_a;
  assign bus.alsu_red_op_B  = cmd_f.red_op_b;
  assign bus.alsu_byPass_A  = cmd_f.bypass_a;
  assign bus.alsu_byPass_B  = cmd_f.bypass_b;

  assign bus.cmd_ready  = !fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.res        = res_q;
  assign bus.res_err    = res_err_q;
  assign bus.res_valid  = res_valid_q;

`ifdef ALSU_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Clear wins over a coincident error capture; the count saturates rather than wraps.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clr)
      err_cnt_d = 8'd0;
    else if (capture && !bus.alsu_valid && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
